// File: rtl/vtp_cmd_arbiter_if.sv
// Bundle of the arbiter's requester, shared-FIFO and response-delivery signals.
// The arbiter side uses the master modport; the surrounding FIFOs use slave.
interface vtp_cmd_arbiter_if #(
    parameter int CMD_WIDTH   = 256,
    parameter int RESP_WIDTH  = 8,
    parameter int ORDER_DEPTH = 8
);
    localparam int OCC_W = $clog2(ORDER_DEPTH) + 1;

    // Handshakes are FIFO style: a pop (rd_en) is only legal while the matching
    // empty is low and takes the head word that same cycle; a push (wr_en) is
    // only started while the matching prog_full is low, which leaves one slot of slack.
    logic                  i_ee_cmd_empty;
    logic [CMD_WIDTH-1:0]  iv_ee_cmd_data;
    logic                  o_ee_cmd_rd_en;
    logic                  i_rwm_cmd_empty;
    logic [CMD_WIDTH-1:0]  iv_rwm_cmd_data;
    logic                  o_rwm_cmd_rd_en;

    logic                  o_vtp_cmd_wr_en;
    logic [CMD_WIDTH-1:0]  ov_vtp_cmd_data;
    logic                  i_vtp_cmd_prog_full;

    logic                  i_vtp_resp_empty;
    logic [RESP_WIDTH-1:0] iv_vtp_resp_data;
    logic                  o_vtp_resp_rd_en;

    logic                  o_ee_resp_wr_en;
    logic [RESP_WIDTH-1:0] ov_ee_resp_data;
    logic                  i_ee_resp_prog_full;
    logic                  o_rwm_resp_wr_en;
    logic [RESP_WIDTH-1:0] ov_rwm_resp_data;
    logic                  i_rwm_resp_prog_full;

    logic [OCC_W-1:0]      ov_outstanding;
    logic [31:0]           ov_ee_cmd_cnt;
    logic [31:0]           ov_rwm_cmd_cnt;

    modport master (
        input  i_ee_cmd_empty, iv_ee_cmd_data,
        output o_ee_cmd_rd_en,
        input  i_rwm_cmd_empty, iv_rwm_cmd_data,
        output o_rwm_cmd_rd_en,
        output o_vtp_cmd_wr_en, ov_vtp_cmd_data,
        input  i_vtp_cmd_prog_full,
        input  i_vtp_resp_empty, iv_vtp_resp_data,
        output o_vtp_resp_rd_en,
        output o_ee_resp_wr_en, ov_ee_resp_data,
        input  i_ee_resp_prog_full,
        output o_rwm_resp_wr_en, ov_rwm_resp_data,
        input  i_rwm_resp_prog_full,
        output ov_outstanding, ov_ee_cmd_cnt, ov_rwm_cmd_cnt
    );

    modport slave (
        output i_ee_cmd_empty, iv_ee_cmd_data,
        input  o_ee_cmd_rd_en,
        output i_rwm_cmd_empty, iv_rwm_cmd_data,
        input  o_rwm_cmd_rd_en,
        input  o_vtp_cmd_wr_en, ov_vtp_cmd_data,
        output i_vtp_cmd_prog_full,
        output i_vtp_resp_empty, iv_vtp_resp_data,
        input  o_vtp_resp_rd_en,
        input  o_ee_resp_wr_en, ov_ee_resp_data,
        output i_ee_resp_prog_full,
        input  o_rwm_resp_wr_en, ov_rwm_resp_data,
        output i_rwm_resp_prog_full,
        input  ov_outstanding, ov_ee_cmd_cnt, ov_rwm_cmd_cnt
    );
endinterface

// File: rtl/vtp_cmd_arbiter.sv
// Round-robin arbiter sharing one VirtToPhys command FIFO between EE and RWM,
// with an order FIFO that steers each response back to its issuer in issue order.
module vtp_cmd_arbiter #(
    parameter int CMD_WIDTH   = 256,
    parameter int RESP_WIDTH  = 8,
    parameter int ORDER_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    vtp_cmd_arbiter_if.master bus
);
    localparam int   PTR_W   = $clog2(ORDER_DEPTH);
    localparam int   OCC_W   = PTR_W + 1;
    localparam logic REQ_EE  = 1'b0;
    localparam logic REQ_RWM = 1'b1;

    logic                  last_grant;
    logic [OCC_W-1:0]      occupancy;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  order_mem [ORDER_DEPTH];
    logic [31:0]           ee_cnt;
    logic [31:0]           rwm_cnt;

    logic                  cmd_wr_en_q;
    logic [CMD_WIDTH-1:0]  cmd_data_q;
    logic                  ee_resp_wr_q;
    logic [RESP_WIDTH-1:0] ee_resp_data_q;
    logic                  rwm_resp_wr_q;
    logic [RESP_WIDTH-1:0] rwm_resp_data_q;

    logic ee_req;
    logic rwm_req;
    logic order_full;
    logic order_empty;
    logic can_grant;
    logic grant_ee;
    logic grant_rwm;
    logic grant_any;
    logic grant_id;
    logic head_id;
    logic head_blocked;
    logic route;

    // Grants are gated by rst so no pop leaks out while the block is held in reset.
    always_comb begin
        ee_req      = !bus.i_ee_cmd_empty;
        rwm_req     = !bus.i_rwm_cmd_empty;
        order_full  = (occupancy == OCC_W'(ORDER_DEPTH));
        order_empty = (occupancy == '0);
        can_grant   = rst && !bus.i_vtp_cmd_prog_full && !order_full && (ee_req || rwm_req);
        grant_ee    = 1'b0;
        grant_rwm   = 1'b0;
        if (can_grant) begin
            if (ee_req && rwm_req) begin
                if (last_grant == REQ_RWM) grant_ee = 1'b1;
                else                       grant_rwm = 1'b1;
            end else begin
                grant_ee  = ee_req;
                grant_rwm = rwm_req;
            end
        end
        grant_any = grant_ee || grant_rwm;
        grant_id  = grant_rwm ? REQ_RWM : REQ_EE;
    end

    always_comb begin
        head_id      = order_mem[rd_ptr];
        head_blocked = (head_id == REQ_RWM) ? bus.i_rwm_resp_prog_full : bus.i_ee_resp_prog_full;
        route        = rst && !bus.i_vtp_resp_empty && !order_empty && !head_blocked;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= REQ_RWM;
        end else if (grant_any) begin
            last_grant <= grant_id;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_wr_en_q <= 1'b0;
            cmd_data_q  <= '0;
        end else begin
            cmd_wr_en_q <= grant_any;
            if (grant_any) begin
                cmd_data_q <= grant_ee ? bus.iv_ee_cmd_data : bus.iv_rwm_cmd_data;
            end
        end
    end

    // Order-FIFO storage needs no reset: only entries between the pointers are read.
    always_ff @(posedge clk) begin
        if (grant_any) begin
            order_mem[wr_ptr] <= grant_id;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (grant_any) wr_ptr <= wr_ptr + 1'b1;
            if (route)     rd_ptr <= rd_ptr + 1'b1;
            case ({grant_any, route})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ee_resp_wr_q    <= 1'b0;
            ee_resp_data_q  <= '0;
            rwm_resp_wr_q   <= 1'b0;
            rwm_resp_data_q <= '0;
        end else begin
            ee_resp_wr_q  <= route && (head_id == REQ_EE);
            rwm_resp_wr_q <= route && (head_id == REQ_RWM);
            if (route && (head_id == REQ_EE))  ee_resp_data_q  <= bus.iv_vtp_resp_data;
            if (route && (head_id == REQ_RWM)) rwm_resp_data_q <= bus.iv_vtp_resp_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ee_cnt  <= '0;
            rwm_cnt <= '0;
        end else begin
            if (grant_ee)  ee_cnt  <= ee_cnt + 32'd1;
            if (grant_rwm) rwm_cnt <= rwm_cnt + 32'd1;
        end
    end

    assign bus.o_ee_cmd_rd_en   = grant_ee;
    assign bus.o_rwm_cmd_rd_en  = grant_rwm;
    assign bus.o_vtp_cmd_wr_en  = cmd_wr_en_q;
    assign bus.ov_vtp_cmd_data  = cmd_data_q;
    assign bus.o_vtp_resp_rd_en = route;
    assign bus.o_ee_resp_wr_en  = ee_resp_wr_q;
    assign bus.ov_ee_resp_data  = ee_resp_data_q;
    assign bus.o_rwm_resp_wr_en = rwm_resp_wr_q;
    assign bus.ov_rwm_resp_data = rwm_resp_data_q;
    assign bus.ov_outstanding   = occupancy;
    assign bus.ov_ee_cmd_cnt    = ee_cnt;
    assign bus.ov_rwm_cmd_cnt   = rwm_cnt;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst)
        !(grant_ee && grant_rwm));
    a_ee_pop_nonempty: assert property (@(posedge clk) disable iff (!rst)
        !(grant_ee && bus.i_ee_cmd_empty));
    a_rwm_pop_nonempty: assert property (@(posedge clk) disable iff (!rst)
        !(grant_rwm && bus.i_rwm_cmd_empty));
    a_occ_bound: assert property (@(posedge clk) disable iff (!rst)
        occupancy <= OCC_W'(ORDER_DEPTH));
    a_pop_nonempty: assert property (@(posedge clk) disable iff (!rst)
        !(route && order_empty));
endmodule

// File: doc/vtp_cmd_arbiter.md
VTP_CMD_ARBITER -- requirements
Module: vtp_cmd_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): CMD_WIDTH, 256, command word width; RESP_WIDTH, 8, response word width; ORDER_DEPTH, 8, maximum number of outstanding commands (power of 2).
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_ee_cmd_empty  in  1  EE command FIFO empty.
- iv_ee_cmd_data  in  CMD_WIDTH  EE command FIFO head (first-word fall-through).
- o_ee_cmd_rd_en  out  1  pop EE command.
- i_rwm_cmd_empty / iv_rwm_cmd_data / o_rwm_cmd_rd_en  in/in/out  1/CMD_WIDTH/1  same interface, RWM requester.
- o_vtp_cmd_wr_en  out  1  write to shared VirtToPhys command FIFO.
- ov_vtp_cmd_data  out  CMD_WIDTH  command word.
- i_vtp_cmd_prog_full  in  1  shared command FIFO backpressure.
- i_vtp_resp_empty  in  1  shared response FIFO empty.
- iv_vtp_resp_data  in  RESP_WIDTH  shared response FIFO head.
- o_vtp_resp_rd_en  out  1  pop shared response.
- o_ee_resp_wr_en / ov_ee_resp_data / i_ee_resp_prog_full  out/out/in  1/RESP_WIDTH/1  response delivery to EE.
- o_rwm_resp_wr_en / ov_rwm_resp_data / i_rwm_resp_prog_full  out/out/in  1/RESP_WIDTH/1  response delivery to RWM.
- ov_outstanding  out  log2(ORDER_DEPTH)+1  current order-FIFO occupancy.
- ov_ee_cmd_cnt, ov_rwm_cmd_cnt  out  32  commands issued per requester.

Function
REQ-003 Grant condition: i_vtp_cmd_prog_full low AND order occupancy < ORDER_DEPTH AND at least one requester non-empty.
REQ-004 Arbitration SHALL be round-robin. A 1-bit last-grant pointer (reset value: RWM) gives priority to the requester not granted last. A lone non-empty requester is granted regardless of the pointer.
REQ-005 The pointer SHALL update only on a grant.
REQ-006 At most one grant per cycle.
REQ-007 o_*_cmd_rd_en SHALL be combinational and equal to the grant for that requester; it is never asserted while the matching empty input is high.
REQ-008 o_vtp_cmd_wr_en and ov_vtp_cmd_data SHALL be registered, one cycle after rd_en (latency 1). Data holds its last value when wr_en is low.
REQ-009 Every grant SHALL push the requester ID (0=EE, 1=RWM) into an internal ORDER_DEPTH-deep order FIFO in the same cycle as rd_en.
REQ-010 Response route condition: i_vtp_resp_empty low AND order FIFO non-empty AND the prog_full of the requester at the order-FIFO head is low.
REQ-011 When the route condition holds, the block SHALL assert o_vtp_resp_rd_en and pop the order FIFO in the same cycle. The next cycle it SHALL assert the target requester's resp_wr_en with the response word (registered, latency 1).
REQ-012 Responses SHALL be delivered strictly in issue order. A blocked head (target prog_full) stalls all responses; there is no bypass.
REQ-013 A simultaneous order-FIFO push and pop SHALL leave the occupancy unchanged. Read and write pointers wrap modulo ORDER_DEPTH.
REQ-014 ov_outstanding SHALL equal the order-FIFO occupancy (0..ORDER_DEPTH). It counts commands granted whose responses have not yet been popped.
REQ-015 ov_ee_cmd_cnt and ov_rwm_cmd_cnt SHALL increment on each respective grant and wrap from 0xFFFFFFFF to 0.
REQ-016 A response arriving while the order FIFO is empty SHALL not be popped. It stays in the shared FIFO; no error is flagged.
REQ-017 i_vtp_cmd_prog_full rising in the same cycle as a grant SHALL not cancel that grant; the registered write still occurs (downstream prog_full slack is at least 1).

Reset
REQ-018 While rst is low, all of the following SHALL be 0: every wr_en and rd_en output, ov_vtp_cmd_data, both resp data outputs, ov_outstanding, both counters, and the order-FIFO pointers. The round-robin pointer SHALL be RWM.
REQ-019 Reset asserted mid-operation SHALL discard in-flight registered writes and order-FIFO contents immediately and asynchronously. Responses still upstream are not the block's responsibility.
REQ-020 The block SHALL resume arbitration on the first rising edge after rst deasserts.

Verification
REQ-021 Both requesters continuously non-empty, no backpressure -> grants alternate EE, RWM, EE, ...; the first grant is EE; one o_vtp_cmd_wr_en per cycle after 1-cycle latency.
REQ-022 Eight commands issued with no responses returned -> ov_outstanding=8; no rd_en while occupancy is 8; one response pop -> one new grant the next cycle.
REQ-023 Issue order EE,RWM,RWM, then responses 0x11,0x22,0x33 -> EE receives 0x11, RWM receives 0x22 then 0x33, each 1 cycle after its o_vtp_resp_rd_en.
REQ-024 i_ee_resp_prog_full held high with an EE response at the order head and an RWM response queued behind -> no o_vtp_resp_rd_en until EE prog_full drops; then in-order delivery.
REQ-025 i_vtp_cmd_prog_full high for 5 cycles with both requesters non-empty -> no rd_en and no wr_en during that window; the pointer is unchanged.
REQ-026 Reset pulsed low with occupancy 5 and a write pending -> all outputs 0 immediately; after release the first grant goes to EE.
